// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// matrix geometry and the key index assigned to each legend.
package keypad_pkg;

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int         ROWS    = 4;
    localparam int         COLS    = 4;
    localparam logic [3:0] COL_RST = 4'b1110;

    // Key index is row*4 + col on the standard telephone-style layout.
    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_B    = 4'd7;
    localparam logic [3:0] KEY_7    = 4'd8;
    localparam logic [3:0] KEY_8    = 4'd9;
    localparam logic [3:0] KEY_9    = 4'd10;
    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_0    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    // Index of the lowest row line pulled low; 0 when none is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        lowest_low = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) lowest_low = 2'(i);
        end
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
// Resets to all-ones, i.e. "no row pulled low".
module row_sync #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad front end: drives one column low per dwell period,
// freezes on a press, and hands confirmed keys out through a valid/ready register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_down,
    input  logic       tecla_i,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overrun,
    output state_t     state_dbg_o
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [3:0]    row_s;
    logic [CW-1:0] cnt_q;
    logic          tick;

    state_t        state_q;
    logic [3:0]    col_q;
    logic [1:0]    col_idx_q;
    logic          key_down_q;
    logic [3:0]    scan_code_q;

    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          overrun_q, overrun_d;
    logic          hs, honour, load;

    row_sync #(.W(ROWS)) u_row_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (row_i),
        .q_o    (row_s)
    );

    // Dwell counter runs in every state so HOLD re-checks rows once per dwell.
    assign tick = (cnt_q == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCAN;
            col_q       <= COL_RST;
            col_idx_q   <= 2'd0;
            key_down_q  <= 1'b0;
            scan_code_q <= 4'd0;
        end else if (tick) begin
            case (state_q)
                SCAN: begin
                    if (row_s != 4'hF) begin
                        state_q     <= HOLD;
                        scan_code_q <= {lowest_low(row_s), col_idx_q};
                        key_down_q  <= 1'b1;
                    end else begin
                        col_q     <= {col_q[2:0], col_q[3]};
                        col_idx_q <= col_idx_q + 2'd1;
                    end
                end
                HOLD: begin
                    if (row_s == 4'hF) begin
                        state_q    <= SCAN;
                        key_down_q <= 1'b0;
                        col_q      <= {col_q[2:0], col_q[3]};
                        col_idx_q  <= col_idx_q + 2'd1;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    // A confirmation may refill the register in the same cycle it is drained.
    always_comb begin
        hs          = key_valid_q && key_ready;
        honour      = tecla_i && key_down_q;
        load        = honour && (!key_valid_q || hs);
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overrun_d   = overrun_q;
        if (load) begin
            key_valid_d = 1'b1;
            key_code_d  = scan_code_q;
        end else if (hs) begin
            key_valid_d = 1'b0;
        end
        if (honour && !load) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign col_o       = col_q;
    assign key_down    = key_down_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign overrun     = overrun_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows from the
// pressed-key set and the driven column; accepted keys are scoreboarded.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic       key_down;
    logic       tecla_i = 1'b0;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       overrun;
    state_t     state_dbg;

    logic [15:0] pressed = 16'h0;
    logic [3:0]  exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    keypad_scanner #(.SCAN_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_down    (key_down),
        .tecla_i     (tecla_i),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .overrun     (overrun),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key sits in a driven column.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_kd(input logic val, input string name);
        for (int i = 0; i < 4*DIV + 8; i++) begin
            if (key_down === val) break;
            cyc(1);
        end
        chk(name, 16'(key_down), 16'(val));
    endtask

    task automatic pulse_tecla(input logic rdy);
        tecla_i   = 1'b1;
        key_ready = rdy;
        cyc(1);
        tecla_i   = 1'b0;
        key_ready = 1'b0;
    endtask

    task automatic pulse_ready();
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst && key_valid && key_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL accept_unexpected: got %0d expected none", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code === e) n_pass++;
                else $display("FAIL accept_code: got %0d expected %0d", key_code, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset and free-running scan
        cyc(2);
        chk("rst_col", 16'(col_o), 16'(4'b1110));
        chk("rst_kd", 16'(key_down), 16'd0);
        chk("rst_valid", 16'(key_valid), 16'd0);
        chk("rst_code", 16'(key_code), 16'd0);
        chk("rst_ovr", 16'(overrun), 16'd0);
        chk("rst_state", 16'(state_dbg), 16'(SCAN));
        rst = 1'b1;
        cyc(7);
        chk("scan_c0_end", 16'(col_o), 16'(4'b1110));
        cyc(1);
        chk("scan_c1", 16'(col_o), 16'(4'b1101));
        cyc(7);
        chk("scan_c1_end", 16'(col_o), 16'(4'b1101));
        cyc(1);
        chk("scan_c2", 16'(col_o), 16'(4'b1011));
        cyc(8);
        chk("scan_c3", 16'(col_o), 16'(4'b0111));
        cyc(8);
        chk("scan_wrap", 16'(col_o), 16'(4'b1110));
        chk("scan_kd", 16'(key_down), 16'd0);
        chk("scan_valid", 16'(key_valid), 16'd0);
        chk("scan_ovr", 16'(overrun), 16'd0);

        // Key 6: row 1, column 2
        pressed = 16'h0040;
        wait_kd(1'b1, "k6_down");
        chk("k6_col", 16'(col_o), 16'(4'b1011));
        chk("k6_state", 16'(state_dbg), 16'(HOLD));
        cyc(DIV);
        chk("k6_frozen", 16'(col_o), 16'(4'b1011));
        exp_q.push_back(4'd6);
        pulse_tecla(1'b0);
        chk("k6_valid", 16'(key_valid), 16'd1);
        chk("k6_code", 16'(key_code), 16'd6);
        pulse_ready();
        chk("k6_drained", 16'(key_valid), 16'd0);

        // Release: scan resumes at the next column; tecla ignored when idle
        pressed = 16'h0;
        wait_kd(1'b0, "rel_up");
        chk("rel_col", 16'(col_o), 16'(4'b0111));
        chk("rel_state", 16'(state_dbg), 16'(SCAN));
        pulse_tecla(1'b0);
        chk("idle_tecla", 16'(key_valid), 16'd0);

        // Rows 0 and 3 low in column 1: lowest row wins
        pressed = 16'h2002;
        wait_kd(1'b1, "k1_down");
        chk("k1_col", 16'(col_o), 16'(4'b1101));
        exp_q.push_back(4'd1);
        pulse_tecla(1'b0);
        chk("k1_valid", 16'(key_valid), 16'd1);
        chk("k1_code", 16'(key_code), 16'd1);

        // Leave key 1 pending, move to key 6, confirm with a same-cycle drain
        pressed = 16'h0;
        wait_kd(1'b0, "k1_up");
        pressed = 16'h0040;
        wait_kd(1'b1, "k6b_down");
        chk("k6b_col", 16'(col_o), 16'(4'b1011));
        chk("k1_held", 16'(key_code), 16'd1);
        exp_q.push_back(4'd6);
        pulse_tecla(1'b1);
        chk("refill_valid", 16'(key_valid), 16'd1);
        chk("refill_code", 16'(key_code), 16'd6);
        chk("refill_ovr", 16'(overrun), 16'd0);

        // Full register, no ready: key dropped, overrun sticky
        pulse_tecla(1'b0);
        chk("ovr_code", 16'(key_code), 16'd6);
        chk("ovr_valid", 16'(key_valid), 16'd1);
        chk("ovr_flag", 16'(overrun), 16'd1);
        cyc(3);
        chk("ovr_sticky", 16'(overrun), 16'd1);

        // Asynchronous reset mid-HOLD with a pending key
        #3;
        rst = 1'b0;
        #1;
        chk("arst_col", 16'(col_o), 16'(4'b1110));
        chk("arst_kd", 16'(key_down), 16'd0);
        chk("arst_valid", 16'(key_valid), 16'd0);
        chk("arst_code", 16'(key_code), 16'd0);
        chk("arst_ovr", 16'(overrun), 16'd0);
        chk("arst_state", 16'(state_dbg), 16'(SCAN));
        exp_q.delete();
        pressed = 16'h0;
        cyc(2);
        rst = 1'b1;
        cyc(7);
        chk("restart_c0", 16'(col_o), 16'(4'b1110));
        cyc(1);
        chk("restart_c1", 16'(col_o), 16'(4'b1101));
        chk("restart_valid", 16'(key_valid), 16'd0);

        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
